// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the IF/ID pipeline stage
package pipe_pkg;

    // MIPS sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OCC_W = 2;

    // Number of held entries from the two slot valid bits
    function automatic logic [OCC_W-1:0] occ_count(input logic m_v, input logic s_v);
        return {1'b0, m_v} + {1'b0, s_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data storage slot with load/clear and async reset
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear wins over load; a clear still writes i_data so the caller can scrub or hold contents
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= i_data;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with valid/ready, optional skid slot, flush and stall counter
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W  = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR),
    parameter bit                 SKID    = 1'b1,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int DW = ADDR_W + INSTR_W;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } slot_t;

    slot_t            w_m;
    slot_t            w_s;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_m_take;
    logic             w_m_load;
    logic             w_m_clear;
    logic [DW-1:0]    w_m_din;
    logic [DW-1:0]    w_m_q;
    logic [DW-1:0]    w_in_data;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_m.valid & out_ready;
    assign w_in_data  = {in_pc4, in_instr};

    // M can accept new contents when it is empty or its pair is leaving this edge
    assign w_m_take  = !w_m.valid | w_out_fire;
    assign w_m_load  = !flush & w_m_take & (w_s.valid | w_in_fire);
    assign w_m_clear = flush | (w_m_take & !w_s.valid & !w_in_fire);

    // Skid contents always drain into M before new input, keeping FIFO order
    always_comb begin
        w_m_din = {w_m.pc4, w_m.instr};
        if (flush) begin
            w_m_din = {w_m.pc4, NOP};
        end else if (w_s.valid) begin
            w_m_din = {w_s.pc4, w_s.instr};
        end else if (w_in_fire) begin
            w_m_din = w_in_data;
        end
    end

    pipe_slot #(.W(DW)) u_m_slot (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_din),
        .o_valid (w_m.valid),
        .o_data  (w_m_q)
    );

    assign w_m.pc4   = w_m_q[DW-1:INSTR_W];
    assign w_m.instr = w_m_q[INSTR_W-1:0];

    generate
        if (SKID) begin : g_skid
            logic          w_s_load;
            logic          w_s_clear;
            logic [DW-1:0] w_s_din;
            logic [DW-1:0] w_s_q;

            // S only captures input while M is held; it empties when drained into M or flushed
            assign w_s_load  = !flush & w_m.valid & !w_out_fire & w_in_fire;
            assign w_s_clear = flush | (w_s.valid & w_m_take);
            assign w_s_din   = w_s_load ? w_in_data : w_s_q;

            pipe_slot #(.W(DW)) u_s_slot (
                .clk     (clk),
                .rstn    (rstn),
                .i_load  (w_s_load),
                .i_clear (w_s_clear),
                .i_data  (w_s_din),
                .o_valid (w_s.valid),
                .o_data  (w_s_q)
            );

            assign w_s.pc4   = w_s_q[DW-1:INSTR_W];
            assign w_s.instr = w_s_q[INSTR_W-1:0];

            // Registered ready: depends only on the skid slot state
            assign in_ready = !w_s.valid;
        end else begin : g_noskid
            assign w_s      = '0;
            // Single entry: accept when M is empty or being consumed this cycle
            assign in_ready = out_ready | !w_m.valid;
        end
    endgenerate

    // Saturating count of edges where fetch waits on a full stage, ignoring flush cycles
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = w_m.valid;
    assign out_pc4   = w_m.pc4;
    assign out_instr = w_m.valid ? w_m.instr : NOP;
    assign occupancy = occ_count(w_m.valid, w_s.valid);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, optional two-entry skid buffering, synchronous flush with NOP injection, and a saturating stall counter. It sits between instruction fetch (PC+4 adder and instruction memory) and decode. It replaces the single-entry hit-gated latch and lets decode stall without losing an in-flight fetch.

## Interface
Parameters:
- `ADDR_W`, 32: width of the PC+4 field.
- `INSTR_W`, 32: width of the instruction field.
- `NOP`, `INSTR_W'h0`: instruction value driven while the stage is empty or flushed.
- `SKID`, 1: 1 selects the two-entry skid buffer; 0 selects a single-entry register with a combinational ready path.
- `CNT_W`, 16: width of the stall counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1: clock. All state updates happen on the falling edge.
  - `rstn`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: fetch presents a valid PC+4/instruction pair.
- `in_ready`, output, 1: stage accepts the pair this cycle.
- `in_pc4`, input, `ADDR_W`: PC+4 from the fetch adder.
- `in_instr`, input, `INSTR_W`: fetched instruction.
- `flush`, input, 1: squash all contents (branch/jump redirect).
- `out_valid`, output, 1: decode-side pair is valid.
- `out_ready`, input, 1: decode consumes the pair this cycle.
- `out_pc4`, output, `ADDR_W`: registered PC+4.
- `out_instr`, output, `INSTR_W`: registered instruction, or `NOP` when `out_valid` is 0.
- `occupancy`, output, 2: number of held entries (0..2).
- `stall_cnt`, output, `CNT_W`: count of cycles with `in_valid & !in_ready`. Saturates at all-ones.

## Operation
- Transfer events:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- Storage: main slot M (drives outputs) and skid slot S (present only when SKID=1). Each slot holds `{valid, pc4, instr}`.
- Ready:
  - SKID=1: `in_ready = !S.valid`. It is registered, with no combinational path from `out_ready`.
  - SKID=0: `in_ready = out_ready | !M.valid`.
- Outputs: `out_valid = M.valid` and `out_pc4 = M.pc4`. `out_instr = M.valid ? M.instr : NOP`.
- Update per falling edge. Rules are in priority order:
  1. `flush`: M.valid and S.valid go to 0, and M.instr goes to NOP. Any same-cycle `in_fire` is discarded, so wrong-path fetch is dropped.
  2. M empty or `out_fire`:
     - If S.valid, M takes S and S.valid goes to 0.
     - Else, if `in_fire`, M takes the input.
     - Else M.valid goes to 0.
  3. M held (valid and not consumed) and `in_fire`: S takes the input and S.valid goes to 1. This case is only possible when SKID=1.
- In SKID=1, S is never written while S.valid is set, because `in_ready` is 0 then. Data order is strictly preserved (FIFO).
- `occupancy = M.valid + S.valid`.
- `stall_cnt` increments on each edge where `in_valid & !in_ready` and `flush` is low. It holds at `2^CNT_W-1` and clears only on reset.

## Timing
- Reset (async assert, any time, including mid-transfer):
  - M.valid=0 and S.valid=0; all stored data is 0.
  - `out_instr=NOP`, `out_valid=0`, `out_pc4=0`.
  - `in_ready=1`, `occupancy=0`, `stall_cnt=0`.
  - Held entries are discarded.
- Deassertion of `rstn` is taken as synchronous to the next falling edge.
- Latency: input accepted at edge k appears on outputs after edge k when M was free.
- Throughput: one pair per cycle with `out_ready` held high. No bubble is inserted in either mode.
- SKID=1 full case: after two accepts with `out_ready=0`, `in_ready` drops for the following cycle. The first `out_fire` moves S into M and raises `in_ready` one edge later.
- Simultaneous `in_fire` and `out_fire` with S empty: M is replaced in the same edge and occupancy is unchanged.
- Flush together with `out_fire`: the consumed pair counts as delivered, and the stage still ends empty.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSTR` constant (MIPS `sll $0,$0,0` = 0).
  - Slot struct typedef `{valid, pc4, instr}`, parameterised by the widths via the module.
- Natural sub-module `pipe_slot`: one valid+data register with load/clear/async-reset. It is instantiated once for M and once for S, with S under `generate if (SKID)`.

## Test plan
- Reset mid-stream: fill two entries, pulse `rstn`=0.
  - Expect immediately `out_valid=0`, `out_instr=0`, `occupancy=0`, `in_ready=1`, `stall_cnt=0`.
- Streaming, SKID=1: feed pc4=4,8,12 with instrs A,B,C and `out_ready=1`.
  - Expect outputs 4/A, 8/B, 12/C on consecutive edges, one edge after acceptance.
- Backpressure: `out_ready=0`, present 4/A, 8/B, 12/C.
  - Expect A and B accepted, `in_ready=0`, `occupancy=2`.
  - `stall_cnt` increments each cycle C waits.
  - Raise `out_ready`: expect A, B, C in order with no loss.
- Flush: with `occupancy=2` and `in_valid=1` carrying 16/D, assert `flush` for one cycle.
  - Expect `occupancy=0`, `out_instr=NOP`, and D never appears.
- SKID=0 build: `out_ready=0` with M full.
  - Expect `in_ready=0` combinationally.
  - Toggle `out_ready=1`: expect same-cycle `in_ready=1` and M replaced at the next edge.
- Saturation, `CNT_W=4`: hold the stall for 20 cycles.
  - Expect `stall_cnt` to stop at 15.
